// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// Holds the funct3 encodings, the FSM states and the per-op operand sign rules.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  localparam int MDU_ITER = 32;

  function automatic logic is_div(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_rem(input mdu_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // MUL's low word is sign-agnostic, so it is handled as signed/signed.
  function automatic logic a_signed(input mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// One restoring-divide step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the result only if non-negative.
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // The partial remainder stays below the divisor, so the 33-bit trial
  // difference is negative exactly when its top bit is set.
  always_comb begin
    rem_sh = {rem_i, quo_i[XLEN-1]};
    diff   = rem_sh - {1'b0, div_i};
    if (!diff[XLEN]) begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step
// per cycle on operand magnitudes, with the sign applied when the result is written.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            rd_wren_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o
);

  localparam int            CNT_W     = $clog2(MDU_ITER);
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(MDU_ITER - 1);

  function automatic logic [XLEN-1:0] neg_w(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_d(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  mdu_state_e          state_q, state_d;
  mdu_op_e             op_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [XLEN-1:0]     a_mag_q, b_mag_q, rem_q, spec_res_q;
  logic [2*XLEN-1:0]   acc_q;
  logic                res_neg_q, spec_q;

  mdu_op_e             op_in;
  logic                sa_in, sb_in, div0_in, ovf_in, spec_in, fast_in, res_neg_in, start_ok;
  logic [XLEN-1:0]     a_mag_in, b_mag_in, spec_res_in;

  // Operand decode at launch: magnitudes, result sign, special-case result
  always_comb begin
    op_in      = mdu_op_e'(funct3_i);
    sa_in      = a_signed(op_in) & rs1_data_i[XLEN-1];
    sb_in      = b_signed(op_in) & rs2_data_i[XLEN-1];
    a_mag_in   = neg_w(sa_in, rs1_data_i);
    b_mag_in   = neg_w(sb_in, rs2_data_i);
    res_neg_in = is_rem(op_in) ? sa_in : (sa_in ^ sb_in);
    div0_in    = is_div(op_in) && (rs2_data_i == '0);
    ovf_in     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                 (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1);
    spec_in    = div0_in | ovf_in;
    spec_res_in = '0;
    if (div0_in)
      spec_res_in = is_rem(op_in) ? rs1_data_i : '1;
    else if (ovf_in)
      spec_res_in = is_rem(op_in) ? '0 : rs1_data_i;
    fast_in    = FAST_SPECIAL && spec_in;
    start_ok   = start_i && !flush_i && (state_q == IDLE);
  end

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt, acc_nxt, prod;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, res_calc;

  mdu_div_iter #(.XLEN(XLEN)) u_div_iter (
    .rem_i (rem_q),
    .quo_i (acc_q[XLEN-1:0]),
    .div_i (b_mag_q),
    .rem_o (rem_nxt),
    .quo_o (quo_nxt)
  );

  // Iteration step: the multiplier sits in the low half of acc and is shifted
  // out as the partial product grows in from the top; divide keeps the quotient there.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? a_mag_q : '0)};
    mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    acc_nxt  = is_div(op_q) ? {acc_q[2*XLEN-1:XLEN], quo_nxt} : mul_nxt;
    prod     = neg_d(res_neg_q, mul_nxt);
    case (op_q)
      OP_MUL:                      res_calc = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_calc = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             res_calc = neg_w(res_neg_q, quo_nxt);
      default:                     res_calc = neg_w(res_neg_q, rem_nxt);
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = fast_in ? DONE : CALC;
      CALC:    if (cnt_q == ITER_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q       <= OP_MUL;
      cnt_q      <= '0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      spec_res_q <= '0;
      res_neg_q  <= 1'b0;
      spec_q     <= 1'b0;
      rd_addr_o  <= '0;
      rd_data_o  <= '0;
    end else if (start_ok) begin
      op_q       <= op_in;
      cnt_q      <= '0;
      a_mag_q    <= a_mag_in;
      b_mag_q    <= b_mag_in;
      rem_q      <= '0;
      acc_q      <= {{XLEN{1'b0}}, (is_div(op_in) ? a_mag_in : b_mag_in)};
      spec_res_q <= spec_res_in;
      res_neg_q  <= res_neg_in;
      spec_q     <= spec_in;
      rd_addr_o  <= rd_addr_i;
      if (fast_in) rd_data_o <= spec_res_in;
    end else if ((state_q == CALC) && !flush_i) begin
      acc_q <= acc_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == ITER_LAST) rd_data_o <= spec_q ? spec_res_q : res_calc;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign rd_wren_o = done_o && (rd_addr_o != 5'd0);

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: arithmetic results, latency, special cases,
// flush, asynchronous reset and start-while-busy.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [4:0]  rd_addr = '0;
  logic        busy, done, wren;
  logic [4:0]  rd_addr_q;
  logic [31:0] rd_data;

  int n_cmp = 0;
  int n_fail = 0;

  mdu_iter #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .flush_i    (flush),
    .funct3_i   (funct3),
    .rs1_data_i (rs1),
    .rs2_data_i (rs2),
    .rd_addr_i  (rd_addr),
    .busy_o     (busy),
    .done_o     (done),
    .rd_wren_o  (wren),
    .rd_addr_o  (rd_addr_q),
    .rd_data_o  (rd_data)
  );

  always #5 clk = ~clk;

  // Issue one op (called #1 after a rising edge); latency counts cycles from the start edge.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res, output int lat,
                       output logic wr, output logic done_nxt);
    start = 1'b1; funct3 = f; rs1 = a; rs2 = b; rd_addr = rd;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; res = '0; wr = 1'b0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done) begin
      res = rd_data;
      wr  = wren;
    end else begin
      lat = -1;
    end
    @(posedge clk); #1;
    done_nxt = done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++; if ({busy, done, wren} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got=%b want=000", {busy, done, wren}); end
    n_cmp++; if (rd_addr_q !== 5'd0) begin n_fail++; $display("FAIL reset_addr got=%0d want=0", rd_addr_q); end
    n_cmp++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h want=00000000", rd_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    logic [31:0] r; int lat; logic wr, dn;
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, r, lat, wr, dn);
    n_cmp++; if (r !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_data got=%h want=ffffffeb", r); end
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency got=%0d want=33", lat); end
    n_cmp++; if (wr !== 1'b1) begin n_fail++; $display("FAIL mul_wren got=%b want=1", wr); end
    n_cmp++; if (dn !== 1'b0 || wren !== 1'b0) begin n_fail++; $display("FAIL mul_pulse_width got=%b%b want=00", dn, wren); end
    n_cmp++; if (rd_addr_q !== 5'd5) begin n_fail++; $display("FAIL mul_rd got=%0d want=5", rd_addr_q); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_mulh;
    logic [31:0] r; int lat; logic wr, dn;
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, r, lat, wr, dn);
    n_cmp++; if (r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu got=%h want=fffffffe", r); end
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, r, lat, wr, dn);
    n_cmp++; if (r !== 32'h00000000) begin n_fail++; $display("FAIL mulh got=%h want=00000000", r); end
    do_op(3'd2, 32'hFFFFFFFF, 32'd2, 5'd1, r, lat, wr, dn);
    n_cmp++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulhsu got=%h want=ffffffff", r); end
    do_op(3'd0, 32'h12345678, 32'h00010000, 5'd2, r, lat, wr, dn);
    n_cmp++; if (r !== 32'h56780000) begin n_fail++; $display("FAIL mul_shift got=%h want=56780000", r); end
  endtask

  task automatic test_div;
    logic [31:0] r; int lat; logic wr, dn;
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd7, r, lat, wr, dn);
    n_cmp++; if (r !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div got=%h want=fffffffd", r); end
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL div_latency got=%0d want=33", lat); end
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd7, r, lat, wr, dn);
    n_cmp++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rem got=%h want=ffffffff", r); end
    do_op(3'd5, 32'd100, 32'd7, 5'd7, r, lat, wr, dn);
    n_cmp++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu got=%h want=0000000e", r); end
    do_op(3'd7, 32'd100, 32'd7, 5'd7, r, lat, wr, dn);
    n_cmp++; if (r !== 32'd2) begin n_fail++; $display("FAIL remu got=%h want=00000002", r); end
    do_op(3'd7, 32'hFFFFFFFF, 32'h80000000, 5'd7, r, lat, wr, dn);
    n_cmp++; if (r !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL remu_big got=%h want=7fffffff", r); end
  endtask

  task automatic test_div_zero;
    logic [31:0] r; int lat; logic wr, dn;
    do_op(3'd5, 32'd5, 32'd0, 5'd4, r, lat, wr, dn);
    n_cmp++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu_zero got=%h want=ffffffff", r); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL divu_zero_latency got=%0d want=1", lat); end
    do_op(3'd7, 32'd5, 32'd0, 5'd4, r, lat, wr, dn);
    n_cmp++; if (r !== 32'd5) begin n_fail++; $display("FAIL remu_zero got=%h want=00000005", r); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL remu_zero_latency got=%0d want=1", lat); end
    do_op(3'd6, 32'hFFFFFFFB, 32'd0, 5'd4, r, lat, wr, dn);
    n_cmp++; if (r !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL rem_zero got=%h want=fffffffb", r); end
  endtask

  task automatic test_overflow;
    logic [31:0] r; int lat; logic wr, dn;
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd0, r, lat, wr, dn);
    n_cmp++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf got=%h want=80000000", r); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL div_ovf_done got=%0d want=1", lat); end
    n_cmp++; if (wr !== 1'b0) begin n_fail++; $display("FAIL div_ovf_rd0_wren got=%b want=0", wr); end
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd0, r, lat, wr, dn);
    n_cmp++; if (r !== 32'h00000000) begin n_fail++; $display("FAIL rem_ovf got=%h want=00000000", r); end
  endtask

  task automatic test_flush;
    logic [31:0] r; int lat; logic wr, dn; int seen;
    do_op(3'd5, 32'd100, 32'd7, 5'd3, r, lat, wr, dn);
    n_cmp++; if (r !== 32'd14) begin n_fail++; $display("FAIL flush_pre got=%h want=0000000e", r); end
    start = 1'b1; funct3 = 3'd0; rs1 = 32'd7; rs2 = 32'd3; rd_addr = 5'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b want=0", busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || wren) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_done got=%0d want=0", seen); end
    n_cmp++; if (rd_data !== 32'd14) begin n_fail++; $display("FAIL flush_data_held got=%h want=0000000e", rd_data); end
    start = 1'b1; flush = 1'b1; funct3 = 3'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_drop got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r; int lat; logic wr, dn;
    start = 1'b1; funct3 = 3'd5; rs1 = 32'd50; rs2 = 32'd3; rd_addr = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, wren} !== 3'b000) begin n_fail++; $display("FAIL midreset_ctrl got=%b want=000", {busy, done, wren}); end
    n_cmp++; if (rd_addr_q !== 5'd0 || rd_data !== 32'h0) begin n_fail++; $display("FAIL midreset_out got=%0d/%h want=0/00000000", rd_addr_q, rd_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(3'd5, 32'd50, 32'd3, 5'd9, r, lat, wr, dn);
    n_cmp++; if (r !== 32'd16) begin n_fail++; $display("FAIL after_reset got=%h want=00000010", r); end
  endtask

  task automatic test_start_busy;
    int lat; logic [31:0] r;
    start = 1'b1; funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd_addr = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; rd_addr = 5'd12;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 5; r = '0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done) r = rd_data;
    n_cmp++; if (r !== 32'd14) begin n_fail++; $display("FAIL busy_start_data got=%h want=0000000e", r); end
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL busy_start_latency got=%0d want=33", lat); end
    n_cmp++; if (rd_addr_q !== 5'd3) begin n_fail++; $display("FAIL busy_start_rd got=%0d want=3", rd_addr_q); end
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    test_reset;
    test_mul;
    test_mulh;
    test_div;
    test_div_zero;
    test_overflow;
    test_flush;
    test_reset_mid;
    test_start_busy;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
